// File: rtl/sync_line_decoder.sv
// Registered binary-to-one-hot line decoder with a valid/ready input
// handshake, level or fixed-width pulse output, out-of-range error
// flagging and a saturating accept counter.
module sync_line_decoder #(
    parameter int SEL_W     = 2,
    parameter int N_OUT     = 4,
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    output logic             in_ready,
    output logic [N_OUT-1:0] dec_out,
    output logic             out_valid,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] accept_cnt
);

    localparam int              PC_W       = $clog2(PULSE_LEN + 1);
    localparam logic [SEL_W:0]  N_OUT_V    = (SEL_W + 1)'(N_OUT);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_OUT-1:0] dec_q, dec_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;

    logic             accept;
    logic             code_err;
    logic [N_OUT-1:0] dec_code;

    // Handshake: no new code while a pulse is on the lines or the clock is gated
    always_comb begin
        in_ready = en && (state_q != PULSE);
        busy     = (state_q == PULSE);
        accept   = en && in_valid && in_ready && !clr;
    end

    // One-hot decode of the incoming code; codes past the last line decode to zero
    always_comb begin
        code_err = ({1'b0, in_sel} >= N_OUT_V);
        dec_code = code_err ? '0 : ({{(N_OUT - 1){1'b0}}, 1'b1} << in_sel);
    end

    // Next state: clear beats accept; pulse counter counts cycles already shown
    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        pcnt_d      = pcnt_q;
        if (en) begin
            if (clr) begin
                state_d     = IDLE;
                dec_d       = '0;
                out_valid_d = 1'b0;
                err_d       = 1'b0;
                cnt_d       = '0;
                pcnt_d      = '0;
            end else if (accept) begin
                dec_d       = dec_code;
                err_d       = code_err;
                out_valid_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (mode) begin
                    state_d = PULSE;
                    pcnt_d  = PC_W'(1);
                end else begin
                    state_d = HOLD;
                    pcnt_d  = '0;
                end
            end else if (state_q == PULSE) begin
                if (pcnt_q >= PULSE_LAST) begin
                    state_d     = IDLE;
                    dec_d       = '0;
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    pcnt_d      = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            pcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign dec_out    = dec_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_sync_line_decoder.sv
// Bench for sync_line_decoder: three instances with different parameter sets
// share one stimulus stream; each is tracked by its own behavioural model.
module tb_sync_line_decoder;

    logic       clk = 1'b0;
    logic       rst, en, clr, mode, vld;
    logic [2:0] sel;

    logic       rdy_a, ov_a, err_a, busy_a;
    logic [3:0] dec_a;
    logic [7:0] cnt_a;
    logic       rdy_b, ov_b, err_b, busy_b;
    logic [2:0] dec_b;
    logic [1:0] cnt_b;
    logic       rdy_c, ov_c, err_c, busy_c;
    logic [4:0] dec_c;
    logic [2:0] cnt_c;

    int total = 0;
    int bad   = 0;

    // Model state per instance
    logic [4:0] dec_m [3];
    logic       ov_m  [3];
    logic       err_m [3];
    int         cnt_m [3];
    int         left_m[3];

    always #5 clk = ~clk;

    sync_line_decoder #(.SEL_W(2), .N_OUT(4), .PULSE_LEN(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .in_valid(vld),
        .in_sel(sel[1:0]), .in_ready(rdy_a), .dec_out(dec_a), .out_valid(ov_a),
        .err(err_a), .busy(busy_a), .accept_cnt(cnt_a));

    sync_line_decoder #(.SEL_W(2), .N_OUT(3), .PULSE_LEN(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .in_valid(vld),
        .in_sel(sel[1:0]), .in_ready(rdy_b), .dec_out(dec_b), .out_valid(ov_b),
        .err(err_b), .busy(busy_b), .accept_cnt(cnt_b));

    sync_line_decoder #(.SEL_W(3), .N_OUT(5), .PULSE_LEN(2), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .in_valid(vld),
        .in_sel(sel), .in_ready(rdy_c), .dec_out(dec_c), .out_valid(ov_c),
        .err(err_c), .busy(busy_c), .accept_cnt(cnt_c));

    function automatic int nout(int i);
        return (i == 0) ? 4 : (i == 1) ? 3 : 5;
    endfunction

    function automatic int plen(int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int cwid(int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 3;
    endfunction

    // Observed outputs packed as {dec[4:0], out_valid, err, busy, in_ready, cnt[7:0]}
    function automatic logic [16:0] act_of(int i);
        if (i == 0) return {1'b0, dec_a, ov_a, err_a, busy_a, rdy_a, cnt_a};
        if (i == 1) return {2'b0, dec_b, ov_b, err_b, busy_b, rdy_b, 6'b0, cnt_b};
        return {dec_c, ov_c, err_c, busy_c, rdy_c, 5'b0, cnt_c};
    endfunction

    function automatic logic [16:0] exp_of(int i);
        return {dec_m[i], ov_m[i], err_m[i], (left_m[i] != 0),
                (en && left_m[i] == 0), 8'(cnt_m[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            dec_m[i] = '0; ov_m[i] = 1'b0; err_m[i] = 1'b0;
            cnt_m[i] = 0;  left_m[i] = 0;
        end
    endtask

    // Advance the models by one clock using the currently driven inputs,
    // then move to just after the rising edge.
    task automatic step();
        int s;
        for (int i = 0; i < 3; i++) begin
            if (en) begin
                if (clr) begin
                    dec_m[i] = '0; ov_m[i] = 1'b0; err_m[i] = 1'b0;
                    cnt_m[i] = 0;  left_m[i] = 0;
                end else if (vld && left_m[i] == 0) begin
                    s = (i == 2) ? int'(sel) : int'(sel[1:0]);
                    if (s < nout(i)) begin
                        dec_m[i] = 5'(1 << s);
                        err_m[i] = 1'b0;
                    end else begin
                        dec_m[i] = '0;
                        err_m[i] = 1'b1;
                    end
                    ov_m[i] = 1'b1;
                    if (cnt_m[i] < (1 << cwid(i)) - 1) cnt_m[i]++;
                    left_m[i] = mode ? plen(i) : 0;
                end else if (left_m[i] > 0) begin
                    left_m[i]--;
                    if (left_m[i] == 0) begin
                        dec_m[i] = '0; ov_m[i] = 1'b0; err_m[i] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic m,
                         input logic v, input logic [2:0] s);
        en = e; clr = c; mode = m; vld = v; sel = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (act_of(i) !== exp_of(i)) begin
                bad++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, act_of(i), exp_of(i));
            end
        end
        total++;
        if ({dec_a, ov_a, rdy_a, cnt_a} !== {4'b0000, 1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL reset_a got=%b/%b/%b/%0d exp=0000/0/1/0", dec_a, ov_a, rdy_a, cnt_a);
        end
    endtask

    task automatic test_level();
        logic [3:0] want;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 3'(k));
            step();
            want = 4'b0001 << k;
            total++;
            if (dec_a !== want || ov_a !== 1'b1) begin
                bad++;
                $display("FAIL level_sel%0d got=%b exp=%b", k, dec_a, want);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (act_of(i) !== exp_of(i)) begin
                    bad++;
                    $display("FAIL level dut%0d got=%h exp=%h", i, act_of(i), exp_of(i));
                end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        step();
        total++;
        if (dec_a !== 4'b1000 || cnt_a !== 8'd4) begin
            bad++;
            $display("FAIL level_hold got=%b cnt=%0d exp=1000 cnt=4", dec_a, cnt_a);
        end
    endtask

    task automatic test_pulse();
        logic [2:0] want_dec [5] = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b100};
        logic       want_bsy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (dec_b !== want_dec[k] || busy_b !== want_bsy[k] || rdy_b !== !want_bsy[k]) begin
                bad++;
                $display("FAIL pulse_b cyc%0d got=%b busy=%b rdy=%b exp=%b busy=%b",
                         k, dec_b, busy_b, rdy_b, want_dec[k], want_bsy[k]);
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (act_of(i) !== exp_of(i)) begin
                    bad++;
                    $display("FAIL pulse dut%0d got=%h exp=%h", i, act_of(i), exp_of(i));
                end
            end
        end
    endtask

    task automatic test_err();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        step();
        total++;
        if ({dec_b, err_b, ov_b, cnt_b} !== {3'b000, 1'b1, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL err_b got=%b err=%b ov=%b cnt=%0d exp=000 err=1 ov=1 cnt=1",
                     dec_b, err_b, ov_b, cnt_b);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (act_of(i) !== exp_of(i)) begin
                bad++;
                $display("FAIL err dut%0d got=%h exp=%h", i, act_of(i), exp_of(i));
            end
        end
    endtask

    task automatic test_en_freeze();
        int seen = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd4);
        step();
        if (dec_c == 5'b10000) seen++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            if (dec_c == 5'b10000) seen++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            if (dec_c == 5'b10000) seen++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (act_of(i) !== exp_of(i)) begin
                    bad++;
                    $display("FAIL en_freeze dut%0d got=%h exp=%h", i, act_of(i), exp_of(i));
                end
            end
        end
        total++;
        if (seen != 4 || cnt_c !== 3'd1) begin
            bad++;
            $display("FAIL en_freeze_len got=%0d cnt=%0d exp=4 cnt=1", seen, cnt_c);
        end
    endtask

    task automatic test_clr();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        step();
        total++;
        if ({dec_a, ov_a, cnt_a} !== {4'b0000, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL clr_a got=%b ov=%b cnt=%0d exp=0000 ov=0 cnt=0", dec_a, ov_a, cnt_a);
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 3'(k));
            step();
        end
        total++;
        if (cnt_b !== 2'd3 || cnt_a !== 8'd5 || cnt_c !== 3'd5) begin
            bad++;
            $display("FAIL saturate got=%0d/%0d/%0d exp=5/3/5", cnt_a, cnt_b, cnt_c);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({dec_b, busy_b, dec_c, busy_c} !== {3'b000, 1'b0, 5'b00000, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid got=%b/%b %b/%b exp=000/0 00000/0", dec_b, busy_b, dec_c, busy_c);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (act_of(i) !== exp_of(i)) begin
                    bad++;
                    $display("FAIL rst_mid_after dut%0d got=%h exp=%h", i, act_of(i), exp_of(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
                  1'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom));
            step();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (act_of(i) !== exp_of(i)) begin
                    bad++;
                    $display("FAIL random cyc%0d dut%0d got=%h exp=%h", k, i, act_of(i), exp_of(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        #12;
        test_reset();
        test_level();
        test_pulse();
        test_err();
        test_en_freeze();
        test_clr();
        test_saturate();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
